// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch resolution sequencer: accepts one conditional branch at a time, resolves it
// against the fetch prediction, and on mispredict flushes IF/ID then hands the corrected PC to fetch.
module branch_redirect_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid_in,
  output logic             br_ready_out,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  target_in,
  input  logic             compressed_in,
  input  logic             pred_taken_in,
  output logic             branch_en_out,
  input  logic             branch_taken_in,
  input  logic             kill_in,
  output logic             flush_out,
  output logic             redirect_valid_out,
  input  logic             redirect_ready_in,
  output logic [XLEN-1:0]  redirect_pc_out,
  output logic             resolved_valid_out,
  output logic             resolved_taken_out,
  output logic [CNT_W-1:0] branch_cnt_out,
  output logic [CNT_W-1:0] mispred_cnt_out
);

  localparam int unsigned FCNT_W  = 4;
  localparam logic [FCNT_W-1:0] FLUSH_LD = FCNT_W'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic               flush_q, flush_d;
  logic               rvalid_q, rvalid_d;
  logic [XLEN-1:0]    rpc_q, rpc_d;
  logic               res_valid_q, res_valid_d;
  logic               res_taken_q, res_taken_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;
  logic [CNT_W-1:0]   mcnt_q, mcnt_d;

  logic               accept_c;
  logic               mispredict_c;
  logic [XLEN-1:0]    correct_pc_c;

  assign br_ready_out  = (state_q == IDLE);
  assign accept_c      = br_valid_in & br_ready_out & ~kill_in;
  assign branch_en_out = accept_c;
  assign mispredict_c  = accept_c & (branch_taken_in ^ pred_taken_in);
  assign correct_pc_c  = branch_taken_in ? target_in
                       : pc_in + (compressed_in ? XLEN'(2) : XLEN'(4));

  // Next-state, resolve reporting and statistics; kill overrides every transition.
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    flush_d     = flush_q;
    rvalid_d    = rvalid_q;
    rpc_d       = accept_c ? correct_pc_c : rpc_q;
    res_valid_d = accept_c;
    res_taken_d = accept_c ? branch_taken_in : res_taken_q;
    bcnt_d      = (accept_c && !(&bcnt_q)) ? bcnt_q + CNT_W'(1) : bcnt_q;
    mcnt_d      = (mispredict_c && !(&mcnt_q)) ? mcnt_q + CNT_W'(1) : mcnt_q;

    unique case (state_q)
      IDLE: begin
        if (mispredict_c) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_LD;
          flush_d = 1'b1;
        end
      end
      FLUSH: begin
        if (fcnt_q <= FCNT_W'(1)) begin
          state_d  = REDIRECT;
          flush_d  = 1'b0;
          rvalid_d = 1'b1;
        end else begin
          fcnt_d  = fcnt_q - FCNT_W'(1);
          flush_d = 1'b1;
        end
      end
      REDIRECT: begin
        if (redirect_ready_in) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        flush_d  = 1'b0;
        rvalid_d = 1'b0;
      end
    endcase

    if (kill_in) begin
      state_d  = IDLE;
      flush_d  = 1'b0;
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fcnt_q      <= '0;
      flush_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      rpc_q       <= '0;
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
      bcnt_q      <= '0;
      mcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      flush_q     <= flush_d;
      rvalid_q    <= rvalid_d;
      rpc_q       <= rpc_d;
      res_valid_q <= res_valid_d;
      res_taken_q <= res_taken_d;
      bcnt_q      <= bcnt_d;
      mcnt_q      <= mcnt_d;
    end
  end

  assign flush_out          = flush_q;
  assign redirect_valid_out = rvalid_q;
  assign redirect_pc_out    = rpc_q;
  assign resolved_valid_out = res_valid_q;
  assign resolved_taken_out = res_taken_q;
  assign branch_cnt_out     = bcnt_q;
  assign mispred_cnt_out    = mcnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: directed branches push expected resolves/redirects,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_branch_redirect_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FLUSH = 2;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             br_valid_in;
  logic             br_ready_out;
  logic [XLEN-1:0]  pc_in;
  logic [XLEN-1:0]  target_in;
  logic             compressed_in;
  logic             pred_taken_in;
  logic             branch_en_out;
  logic             branch_taken_in;
  logic             kill_in;
  logic             flush_out;
  logic             redirect_valid_out;
  logic             redirect_ready_in;
  logic [XLEN-1:0]  redirect_pc_out;
  logic             resolved_valid_out;
  logic             resolved_taken_out;
  logic [CNT_W-1:0] branch_cnt_out;
  logic [CNT_W-1:0] mispred_cnt_out;

  branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .br_valid_in(br_valid_in), .br_ready_out(br_ready_out),
    .pc_in(pc_in), .target_in(target_in), .compressed_in(compressed_in),
    .pred_taken_in(pred_taken_in), .branch_en_out(branch_en_out),
    .branch_taken_in(branch_taken_in), .kill_in(kill_in), .flush_out(flush_out),
    .redirect_valid_out(redirect_valid_out), .redirect_ready_in(redirect_ready_in),
    .redirect_pc_out(redirect_pc_out), .resolved_valid_out(resolved_valid_out),
    .resolved_taken_out(resolved_taken_out), .branch_cnt_out(branch_cnt_out),
    .mispred_cnt_out(mispred_cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             taken;
    logic [CNT_W-1:0] bcnt;
    logic [CNT_W-1:0] mcnt;
  } res_t;

  res_t            res_q[$];
  logic [XLEN-1:0] rd_q[$];
  res_t            mon_r;
  int              total = 0;
  int              bad   = 0;
  logic [CNT_W-1:0] exp_b = '0;
  logic [CNT_W-1:0] exp_m = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Monitor: compares every resolve pulse and every presented redirect against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resolved_valid_out) begin
        if (res_q.size() == 0) chk("unexpected_resolve", 1, 0);
        else begin
          mon_r = res_q.pop_front();
          chk("resolved_taken", resolved_taken_out, mon_r.taken);
          chk("branch_cnt", branch_cnt_out, mon_r.bcnt);
          chk("mispred_cnt", mispred_cnt_out, mon_r.mcnt);
        end
      end
      if (redirect_valid_out) begin
        if (rd_q.size() == 0) chk("unexpected_redirect", 1, 0);
        else begin
          chk("redirect_pc", redirect_pc_out, rd_q[0]);
          if (redirect_ready_in) void'(rd_q.pop_front());
        end
      end
    end
  end

  // Issue one branch (called at posedge+1); for a mispredict, walks flush and redirect.
  task automatic branch(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                        input logic c, input logic pred, input logic tk,
                        input int hold, input bit kill_redirect);
    int w = 0;
    int fc = 0;
    res_t r;
    while (!br_ready_out && w < 20) begin @(posedge clk); #1; w++; end
    if (!br_ready_out) chk("ready_wait_timeout", 0, 1);
    br_valid_in = 1'b1; pc_in = pc; target_in = tgt; compressed_in = c;
    pred_taken_in = pred; branch_taken_in = tk;
    #1;
    chk("branch_en", branch_en_out, 1);
    exp_b = sat(exp_b);
    if (pred != tk) exp_m = sat(exp_m);
    r.taken = tk; r.bcnt = exp_b; r.mcnt = exp_m;
    res_q.push_back(r);
    if (pred != tk) rd_q.push_back(tk ? tgt : pc + (c ? XLEN'(2) : XLEN'(4)));
    @(posedge clk); #1;
    br_valid_in = 1'b0; branch_taken_in = 1'b0;
    if (pred == tk) begin
      chk("ready_after_match", br_ready_out, 1);
      chk("no_flush", flush_out, 0);
    end else begin
      chk("ready_low_in_flush", br_ready_out, 0);
      while (flush_out && fc < 20) begin fc++; @(posedge clk); #1; end
      chk("flush_len", fc, FLUSH);
      chk("redirect_valid_rise", redirect_valid_out, 1);
      if (kill_redirect) begin
        kill_in = 1'b1;
        @(posedge clk); #1;
        kill_in = 1'b0;
        rd_q.delete();
        chk("kill_drops_valid", redirect_valid_out, 0);
        chk("kill_ready", br_ready_out, 1);
        chk("kill_flush", flush_out, 0);
      end else begin
        for (int i = 0; i < hold; i++) begin
          chk("valid_while_stalled", redirect_valid_out, 1);
          @(posedge clk); #1;
        end
        redirect_ready_in = 1'b1;
        @(posedge clk); #1;
        redirect_ready_in = 1'b0;
        chk("valid_after_handshake", redirect_valid_out, 0);
        chk("ready_after_handshake", br_ready_out, 1);
      end
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"}, br_ready_out, 1);
    chk({tag, "_flush"}, flush_out, 0);
    chk({tag, "_rvalid"}, redirect_valid_out, 0);
    chk({tag, "_resolved"}, resolved_valid_out, 0);
    chk({tag, "_res_taken"}, resolved_taken_out, 0);
    chk({tag, "_rpc"}, redirect_pc_out, 0);
    chk({tag, "_bcnt"}, branch_cnt_out, 0);
    chk({tag, "_mcnt"}, mispred_cnt_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; br_valid_in = 0; pc_in = '0; target_in = '0; compressed_in = 0;
    pred_taken_in = 0; branch_taken_in = 0; kill_in = 0; redirect_ready_in = 0;
    #1;
    reset_checks("reset");
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    // Correct not-taken prediction, then two back-to-back correct predictions
    branch(32'h100, 32'h80, 0, 0, 0, 0, 0);
    branch(32'h300, 32'h340, 0, 1, 1, 0, 0);
    branch(32'h304, 32'h340, 1, 0, 0, 0, 0);
    // Mispredicts: taken target, compressed fallthrough with stalled fetch, wrap
    branch(32'h100, 32'h80, 0, 0, 1, 0, 0);
    branch(32'h200, 32'h400, 1, 1, 0, 3, 0);
    branch(32'hFFFF_FFFC, 32'h10, 0, 1, 0, 0, 0);
    // Kill in first redirect cycle
    branch(32'h500, 32'h600, 0, 0, 1, 0, 1);
    // Kill in accept cycle: no accept, no resolve
    br_valid_in = 1'b1; kill_in = 1'b1; pc_in = 32'h700; branch_taken_in = 1'b1;
    #1;
    chk("kill_accept_en", branch_en_out, 0);
    @(posedge clk); #1;
    br_valid_in = 1'b0; kill_in = 1'b0; branch_taken_in = 1'b0;
    chk("kill_accept_no_resolve", resolved_valid_out, 0);
    chk("kill_accept_bcnt", branch_cnt_out, exp_b);
    chk("kill_accept_mcnt", mispred_cnt_out, exp_m);

    // Drive both counters into saturation
    for (int i = 0; i < 260; i++) branch(32'h1000, 32'h2000, 0, 0, 1, 0, 0);
    chk("bcnt_saturated", branch_cnt_out, {CNT_W{1'b1}});
    chk("mcnt_saturated", mispred_cnt_out, {CNT_W{1'b1}});

    // Asynchronous reset in the middle of FLUSH
    br_valid_in = 1'b1; pc_in = 32'h900; target_in = 32'hA00; compressed_in = 0;
    pred_taken_in = 0; branch_taken_in = 1;
    @(posedge clk); #1;
    br_valid_in = 1'b0; branch_taken_in = 1'b0;
    chk("pre_reset_flush", flush_out, 1);
    #2 rst_n = 1'b0;
    res_q.delete(); rd_q.delete(); exp_b = '0; exp_m = '0;
    #1;
    reset_checks("midflush_reset");
    repeat (3) @(posedge clk);
    #1;
    chk("reset_no_redirect", redirect_valid_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    branch(32'h40, 32'h80, 0, 0, 0, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("res_q_drained", res_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
